// File: rtl/crc_frame_pkg.sv
`default_nettype none
// ==========================================================================
// crc_frame_pkg : shared widths and FSM encoding for the CRC frame scheduler
// Revision      : 1.0
// ==========================================================================
package crc_frame_pkg;
  localparam int DATA_W = 3;
  localparam int CRC_W  = 4;
  localparam int CODE_W = 7;
  localparam int GAP_W  = 4;
  localparam int BIT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/crc_code_three.sv
`default_nettype none
// ==========================================================================
// crc_code_three : combinational (7,3) CRC, generator x^4 + x^2 + x + 1
// Revision       : 1.0
// ==========================================================================
module crc_code_three
  import crc_frame_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);
  // Remainder of data*x^4; columns are x^6, x^5, x^4 mod g.
  assign o_crc[3] = i_data[2] ^ i_data[1];
  assign o_crc[2] = i_data[1] ^ i_data[0];
  assign o_crc[1] = i_data[2] ^ i_data[1] ^ i_data[0];
  assign o_crc[0] = i_data[2] ^ i_data[0];
endmodule
`default_nettype wire

// File: rtl/crc_frame_sched_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : combinational round-robin pick starting at the pointer
// Revision   : 1.0
// ==========================================================================
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);
  logic [SRC_W:0] w_pos;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // One extra bit so ptr+i never overflows before the modulo wrap.
      w_pos = {1'b0, i_ptr} + (SRC_W+1)'(i);
      if (w_pos >= (SRC_W+1)'(N_REQ)) w_pos = w_pos - (SRC_W+1)'(N_REQ);
      if (!w_found && i_req[w_pos[SRC_W-1:0]]) begin
        w_found                  = 1'b1;
        o_idx                    = w_pos[SRC_W-1:0];
        o_gnt[w_pos[SRC_W-1:0]]  = 1'b1;
      end
    end
    o_any = w_found;
  end
endmodule
`default_nettype wire

// File: rtl/crc_frame_sched.sv
`default_nettype none
// ==========================================================================
// crc_frame_sched : round-robin (7,3) CRC frame builder with serial output
// Revision        : 1.0
// ==========================================================================
module crc_frame_sched
  import crc_frame_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int GAP_CYC = 1,
  localparam int SRC_W   = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [3*N_REQ-1:0]    i_data,
  output logic [N_REQ-1:0]      o_ack,
  output logic [CODE_W-1:0]     o_code,
  output logic                  o_code_valid,
  output logic [SRC_W-1:0]      o_code_src,
  output logic                  o_ser_data,
  output logic                  o_ser_valid,
  output logic                  o_ser_sof,
  output logic                  o_busy
);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                code_valid_q, code_valid_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [CODE_W-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [N_REQ-1:0]    w_gnt;
  logic [SRC_W-1:0]    w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_data;
  logic [CRC_W-1:0]    w_crc;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) w_data = w_data | i_data[3*k +: 3];
    end
  end

  crc_code_three u_crc (
    .i_data (w_data),
    .o_crc  (w_crc)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    code_d       = code_q;
    code_valid_d = 1'b0;
    src_d        = src_q;
    sreg_d       = sreg_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    case (state_q)
      IDLE: begin
        if (i_en && w_any) begin
          ack_d        = w_gnt;
          code_valid_d = 1'b1;
          code_d       = {w_data, w_crc};
          src_d        = w_idx;
          sreg_d       = {w_data, w_crc};
          bit_d        = BIT_W'(CODE_W - 1);
          ptr_d        = (w_idx == SRC_W'(N_REQ - 1)) ? '0 : w_idx + SRC_W'(1);
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[CODE_W-2:0], 1'b0};
        if (bit_q == '0) begin
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      ack_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      src_q        <= '0;
      sreg_q       <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      src_q        <= src_d;
      sreg_q       <= sreg_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
    end
  end

  // Serial outputs decode straight from flops so reset clears them at once.
  assign o_ser_valid  = (state_q == SHIFT);
  assign o_ser_data   = o_ser_valid & sreg_q[CODE_W-1];
  assign o_ser_sof    = o_ser_valid && (bit_q == BIT_W'(CODE_W - 1));
  assign o_busy       = (state_q != IDLE);
  assign o_ack        = ack_q;
  assign o_code       = code_q;
  assign o_code_valid = code_valid_q;
  assign o_code_src   = src_q;
endmodule
`default_nettype wire

// File: tb/tb_crc_frame_sched.sv
`default_nettype none
// ==========================================================================
// tb_crc_frame_sched : directed checks of grant order, codewords and serial
// Revision           : 1.0
// ==========================================================================
module tb_crc_frame_sched;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [3:0]  req   = '0;
  logic [11:0] data  = '0;
  logic [3:0]  req0  = '0;
  logic [11:0] data0 = '0;

  logic [3:0] ack, ack0;
  logic [6:0] code, code0;
  logic       cv, cv0;
  logic [1:0] src, src0;
  logic       sd, sv, sof, busy;
  logic       sd0, sv0, sof0, busy0;

  int checks   = 0;
  int failures = 0;

  crc_frame_sched #(.N_REQ(4), .GAP_CYC(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req), .i_data(data),
    .o_ack(ack), .o_code(code), .o_code_valid(cv), .o_code_src(src),
    .o_ser_data(sd), .o_ser_valid(sv), .o_ser_sof(sof), .o_busy(busy)
  );

  crc_frame_sched #(.N_REQ(4), .GAP_CYC(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1), .i_req(req0), .i_data(data0),
    .o_ack(ack0), .o_code(code0), .o_code_valid(cv0), .o_code_src(src0),
    .o_ser_data(sd0), .o_ser_valid(sv0), .o_ser_sof(sof0), .o_busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cv && n < 40);
    check_eq("grant_seen", cv, 1);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check_eq("back_to_idle", busy, 0);
  endtask

  // Starts on the first SHIFT cycle, ends on the cycle after bit 0.
  task automatic collect_frame(input string tag, input logic [6:0] exp);
    logic [6:0] bits;
    bits = '0;
    for (int i = 0; i < 7; i++) begin
      check_eq({tag, "_valid"}, sv, 1);
      check_eq({tag, "_sof"}, sof, (i == 0) ? 1 : 0);
      bits = {bits[5:0], sd};
      tick();
    end
    check_eq({tag, "_bits"}, bits, exp);
  endtask

  logic [6:0] exp_codes [5];
  logic [1:0] exp_srcs  [5];

  initial begin
    int n;
    int h;
    int l;
    logic [6:0] bits;

    exp_codes = '{7'h00, 7'h39, 7'h72, 7'h5C, 7'h00};
    exp_srcs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    repeat (2) tick();
    check_eq("reset_outs", {ack, code, cv, src, sd, sv, sof, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request, data 101 -> 0x5C
    en        = 1'b1;
    data[2:0] = 3'b101;
    req       = 4'b0001;
    wait_grant(n);
    check_eq("t1_latency", n, 1);
    check_eq("t1_ack", ack, 4'b0001);
    check_eq("t1_code", code, 7'h5C);
    check_eq("t1_src", src, 0);
    check_eq("t1_busy", busy, 1);
    req = 4'b0000;
    collect_frame("t1", 7'h5C);
    check_eq("t1_gap_valid", sv, 0);
    check_eq("t1_gap_data", sd, 0);
    check_eq("t1_gap_busy", busy, 1);
    check_eq("t1_code_held", code, 7'h5C);
    tick();
    check_eq("t1_idle_busy", busy, 0);

    // All requesting from pointer 0: rotation and 9-cycle period
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    data  = 12'b101_111_011_000;
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(n);
      check_eq("t2_period", n, (g == 0) ? 1 : 9);
      check_eq("t2_src", src, exp_srcs[g]);
      check_eq("t2_code", code, exp_codes[g]);
      check_eq("t2_ack", ack, 4'b0001 << exp_srcs[g]);
    end
    req = 4'b0000;
    wait_idle();

    // Pointer is 1; grant 1 moves it to 2, then 0011 picks requester 0
    req = 4'b0010;
    wait_grant(n);
    check_eq("t3_src_a", src, 1);
    req = 4'b0000;
    wait_idle();
    repeat (3) tick();
    check_eq("t3_hold_busy", busy, 0);
    check_eq("t3_hold_src", src, 1);
    check_eq("t3_hold_ack", ack, 0);
    req = 4'b0011;
    wait_grant(n);
    check_eq("t3_src_b", src, 0);
    req = 4'b0010;
    wait_grant(n);
    check_eq("t3_period", n, 9);
    check_eq("t3_src_c", src, 1);
    req = 4'b0000;
    wait_idle();

    // Enable gating; dropping enable mid-frame lets it finish
    en        = 1'b0;
    data[8:6] = 3'b110;
    req       = 4'b0100;
    repeat (3) tick();
    check_eq("t4_no_ack", ack, 0);
    check_eq("t4_no_busy", busy, 0);
    en = 1'b1;
    wait_grant(n);
    check_eq("t4_latency", n, 1);
    check_eq("t4_ack", ack, 4'b0100);
    check_eq("t4_code", code, 7'h65);
    req  = 4'b0000;
    h    = 0;
    bits = '0;
    while (sv && h < 20) begin
      bits = {bits[5:0], sd};
      h++;
      if (h == 2) en = 1'b0;
      tick();
    end
    check_eq("t4_bit_count", h, 7);
    check_eq("t4_bits", bits, 7'h65);
    en = 1'b1;
    wait_idle();

    // Asynchronous reset during the 4th serial bit
    data      = 12'b011_000_000_101;
    req       = 4'b0001;
    wait_grant(n);
    req = 4'b0000;
    repeat (3) tick();
    check_eq("t5_mid_valid", sv, 1);
    rst_n = 1'b0;
    req   = 4'b1001;
    #1;
    check_eq("t5_reset_outs", {ack, code, cv, src, sd, sv, sof, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(n);
    check_eq("t5_latency", n, 1);
    check_eq("t5_src", src, 0);
    check_eq("t5_ack", ack, 4'b0001);
    req = 4'b0000;
    collect_frame("t5", 7'h5C);
    wait_idle();

    // GAP_CYC=0 instance: one IDLE cycle between back-to-back frames
    data0 = 12'b000_000_111_011;
    req0  = 4'b0011;
    n = 0;
    while (!sv0 && n < 40) begin
      tick();
      n++;
    end
    check_eq("t6_start", sv0, 1);
    check_eq("t6_src_a", src0, 0);
    check_eq("t6_code_a", code0, 7'h39);
    h = 0;
    while (sv0 && h < 20) begin
      tick();
      h++;
    end
    check_eq("t6_run_a", h, 7);
    l = 0;
    while (!sv0 && l < 20) begin
      tick();
      l++;
    end
    check_eq("t6_idle_gap", l, 1);
    check_eq("t6_src_b", src0, 1);
    check_eq("t6_code_b", code0, 7'h72);
    h = 0;
    while (sv0 && h < 20) begin
      tick();
      h++;
    end
    check_eq("t6_run_b", h, 7);
    req0 = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
